hqc_rmdecod_peaksched: RTL and testbench

Sequencer for the RM-decoding find-peaks stage of the HQC decapsulation core. Streams each Hadamard-transformed codeword from the transform buffer into the dual-lane find-peaks datapath, issues that datapath's start pulse with the exact alignment it needs, and collects one decoded byte per codeword into the output buffer. It handles N1 codewords per decode run and sits between the Hadamard transform stage and the RS decoder.

---
 rtl/hqc_rmdecod_peaksched_if.sv | 57 +++++
 rtl/hqc_rmdecod_peaksched.sv | 112 +++++++++++
 tb/tb_hqc_rmdecod_peaksched.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/hqc_rmdecod_peaksched_if.sv
// Find-peaks sequencer bundle: run control, transform-buffer
// read side, find-peaks datapath link and output-buffer writes.
interface hqc_rmdecod_peaksched_if #(
    parameter int CNT_W = 7
);
    logic             start_i;
    logic             busy_o;
    logic             done_o;
    logic             err_o;
    logic             wht_ready_i;
    logic             wht_ack_o;
    logic             wht_rd_en_o;
    logic [5:0]       wht_rd_addr_o;
    logic             fp_start_o;
    logic             fp_din_valid_o;
    logic [7:0]       fp_dout_i;
    logic             fp_dout_valid_i;
    logic             out_we_o;
    logic [CNT_W-1:0] out_addr_o;
    logic [7:0]       out_data_o;

    modport master (
        output start_i,
        output wht_ready_i,
        output fp_dout_i,
        output fp_dout_valid_i,
        input  busy_o,
        input  done_o,
        input  err_o,
        input  wht_ack_o,
        input  wht_rd_en_o,
        input  wht_rd_addr_o,
        input  fp_start_o,
        input  fp_din_valid_o,
        input  out_we_o,
        input  out_addr_o,
        input  out_data_o
    );

    modport slave (
        input  start_i,
        input  wht_ready_i,
        input  fp_dout_i,
        input  fp_dout_valid_i,
        output busy_o,
        output done_o,
        output err_o,
        output wht_ack_o,
        output wht_rd_en_o,
        output wht_rd_addr_o,
        output fp_start_o,
        output fp_din_valid_o,
        output out_we_o,
        output out_addr_o,
        output out_data_o
    );
endinterface

// File: rtl/hqc_rmdecod_peaksched.sv
// RM-decode find-peaks sequencer: streams N1 transformed codewords
// into find-peaks and collects one decoded byte per codeword.
module hqc_rmdecod_peaksched #(
    parameter int PARAM_SECURITY = 128,
    parameter int N1 = (PARAM_SECURITY == 256) ? 90 :
                       (PARAM_SECURITY == 192) ? 56 : 46,
    parameter int CNT_W = 7
) (
    input logic clk_i,
    input logic rst_ni,
    hqc_rmdecod_peaksched_if.slave bus
);

    localparam logic [CNT_W-1:0] N1_C = CNT_W'(N1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        STREAM,
        DRAIN
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [5:0]       addr_q;
    logic [CNT_W-1:0] cw_q;
    logic [CNT_W-1:0] res_q;
    logic             err_q;
    logic             dv_q;
    logic             we_q;
    logic [CNT_W-1:0] oaddr_q;
    logic [7:0]       odata_q;
    logic             go;
    logic             last;
    logic             bad;
    logic             accept;
    logic             done;

    assign go     = (state_q == IDLE) && bus.start_i;
    assign last   = (state_q == STREAM) && (addr_q == 6'd63);
    assign bad    = bus.fp_dout_valid_i &&
                    ((state_q == IDLE) || (res_q >= cw_q));
    assign accept = bus.fp_dout_valid_i && !bad;

    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start_i) state_d = WAIT;
            end
            WAIT: begin
                if (bus.wht_ready_i) state_d = STREAM;
            end
            STREAM: begin
                if (last)
                    state_d = (cw_q + ONE < N1_C) ? WAIT : DRAIN;
            end
            DRAIN: begin
                // wait for the last byte to leave the write register
                if (res_q == N1_C && !we_q) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cw_q    <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            dv_q    <= 1'b0;
            we_q    <= 1'b0;
            oaddr_q <= '0;
            odata_q <= '0;
        end else begin
            state_q <= state_d;
            // 64 increments per STREAM wrap back to 0
            if (state_q == STREAM) addr_q <= addr_q + 6'd1;
            if (go)        cw_q <= '0;
            else if (last) cw_q <= cw_q + ONE;
            if (go)          res_q <= '0;
            else if (accept) res_q <= res_q + ONE;
            if (bad)     err_q <= 1'b1;
            else if (go) err_q <= 1'b0;
            dv_q <= (state_q == STREAM);
            we_q <= accept;
            if (accept) begin
                oaddr_q <= res_q;
                odata_q <= bus.fp_dout_i;
            end
        end
    end

    assign bus.busy_o         = (state_q != IDLE);
    assign bus.done_o         = done;
    assign bus.err_o          = err_q;
    assign bus.wht_ack_o      = last;
    assign bus.wht_rd_en_o    = (state_q == STREAM);
    assign bus.wht_rd_addr_o  = addr_q;
    assign bus.fp_start_o     = (state_q == STREAM) && (addr_q == 6'd0);
    assign bus.fp_din_valid_o = dv_q;
    assign bus.out_we_o       = we_q;
    assign bus.out_addr_o     = oaddr_q;
    assign bus.out_data_o     = odata_q;

endmodule

// File: tb/tb_hqc_rmdecod_peaksched.sv
// Bench for hqc_rmdecod_peaksched: find-peaks model feeds a write
// scoreboard; a monitor checks stream alignment and run timing.
module tb_hqc_rmdecod_peaksched;

    logic clk;
    logic rst_ni;
    int   cyc;
    int   t0;
    int   stall_k;
    int   stall_d;
    int   inject_at;
    int   checks;
    int   errors;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } exp_t;

    exp_t exp_q[$];

    hqc_rmdecod_peaksched_if #(.CNT_W(7)) bus ();

    hqc_rmdecod_peaksched #(.PARAM_SECURITY(128)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int sh(input int k);
        return (k >= stall_k) ? stall_d : 0;
    endfunction

    function automatic int outs();
        return int'({bus.busy_o, bus.done_o, bus.err_o, bus.wht_ack_o,
                     bus.wht_rd_en_o, bus.wht_rd_addr_o, bus.fp_start_o,
                     bus.fp_din_valid_o, bus.out_we_o, bus.out_addr_o,
                     bus.out_data_o});
    endfunction

    // find-peaks model: result 2 cycles after the 64th valid
    int mvcnt, mk, fire, fire_k;
    logic mbusy;
    initial begin
        mvcnt = 0; mk = 0; fire = -1; fire_k = 0; mbusy = 1'b0;
    end
    always @(negedge clk) begin
        bus.fp_dout_valid_i = 1'b0;
        bus.fp_dout_i       = 8'h00;
        if (!rst_ni) begin
            mvcnt = 0; mk = 0; fire = -1;
        end else begin
            if (bus.busy_o && !mbusy) begin
                mvcnt = 0; mk = 0;
            end
            if (cyc == inject_at) begin
                bus.fp_dout_valid_i = 1'b1;
                bus.fp_dout_i       = 8'h55;
            end
            if (cyc == fire) begin
                bus.fp_dout_valid_i = 1'b1;
                bus.fp_dout_i       = 8'h80 | 8'(fire_k);
                exp_q.push_back('{fire_k, 32'h80 | fire_k,
                                  t0 + 69 + 65 * fire_k + sh(fire_k)});
            end
            if (bus.fp_din_valid_o) begin
                mvcnt++;
                if (mvcnt == 64) begin
                    mvcnt = 0; fire = cyc + 2; fire_k = mk; mk++;
                end
            end
        end
        mbusy = bus.busy_o;
    end

    // monitor: output writes against scoreboard, stream alignment
    int ks, sc, ea, vl, nwr;
    logic aok, dvp, bp;
    exp_t e;
    initial begin
        ks = 0; sc = 0; ea = 0; vl = 0; nwr = 0;
        aok = 1'b1; dvp = 1'b0; bp = 1'b0;
    end
    always @(negedge clk) begin
        if (!rst_ni) begin
            exp_q.delete();
            ks = 0; nwr = 0; vl = 0; dvp = 1'b0; bp = 1'b0;
        end else begin
            if (bus.busy_o && !bp) begin
                ks = 0; nwr = 0;
            end
            if (bus.out_we_o) begin
                nwr++;
                if (exp_q.size() == 0) begin
                    chk("write_pending", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", int'(bus.out_addr_o), e.addr);
                    chk("wr_data", int'(bus.out_data_o), e.data);
                    chk("wr_cycle", cyc, e.cyc);
                end
            end
            if (bus.fp_start_o) begin
                chk("fp_start_cyc", cyc - t0, 2 + 65 * ks + sh(ks));
                sc = cyc; ea = 0; aok = 1'b1; ks++;
            end
            if (bus.wht_rd_en_o) begin
                if (int'(bus.wht_rd_addr_o) != ea) aok = 1'b0;
                ea++;
            end
            if (bus.fp_din_valid_o && !dvp) begin
                chk("valid_lead", cyc - sc, 1);
                vl = 0;
            end
            if (bus.fp_din_valid_o) vl++;
            if (!bus.fp_din_valid_o && dvp)
                chk("valid_run", vl + (aok ? 0 : 1000), 64);
            if (bus.done_o) begin
                chk("done_cyc", cyc - t0, 2995 + sh(46));
                chk("done_writes", nwr, 46);
                chk("done_pending", exp_q.size(), 0);
            end
            dvp = bus.fp_din_valid_o;
            bp  = bus.busy_o;
        end
    end

    task automatic cycle_to(input int r);
        while (cyc - t0 < r) @(negedge clk);
    endtask

    task automatic start_run();
        @(negedge clk);
        t0 = cyc;
        chk("idle_busy", bus.busy_o, 0);
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        chk("busy_rise", bus.busy_o, 1);
        chk("err_clear", bus.err_o, 0);
    endtask

    task automatic wait_done(input int bound);
        for (int i = 0; i < bound && !bus.done_o; i++) @(negedge clk);
        chk("done_seen", bus.done_o, 1);
        @(negedge clk);
        chk("busy_fall", bus.busy_o, 0);
        chk("err_end", bus.err_o, 0);
    endtask

    initial begin
        checks = 0; errors = 0;
        t0 = 0; stall_k = 99; stall_d = 0; inject_at = -1;
        rst_ni = 1'b0;
        bus.start_i = 1'b0;
        bus.wht_ready_i = 1'b1;
        #1;
        chk("reset_outputs", outs(), 0);
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk);

        // stray result in IDLE: error, no write
        inject_at = cyc + 1;
        repeat (2) @(negedge clk);
        chk("idle_err", bus.err_o, 1);
        chk("idle_no_we", bus.out_we_o, 0);

        // run 1: stall before codeword 3, ignored start at 500
        stall_k = 3; stall_d = 10;
        start_run();
        cycle_to(196);
        bus.wht_ready_i = 1'b0;
        cycle_to(206);
        bus.wht_ready_i = 1'b1;
        cycle_to(500);
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        wait_done(3000);

        // run 2: asynchronous reset mid-STREAM
        stall_k = 99; stall_d = 0;
        start_run();
        cycle_to(1000);
        chk("mid_stream", bus.wht_rd_en_o, 1);
        rst_ni = 1'b0;
        #1;
        chk("async_reset_outputs", outs(), 0);
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;

        // run 3: clean run after reset
        start_run();
        wait_done(3200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
